// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding scoreboard for the in-order pipeline: load-use stall, ID/EX bubble, IF/ID
// flush, registered EX forwarding selects and the HLT drain. Define FWD_EN to enable forwarding.
module hazard_scoreboard #(
    parameter int unsigned REG_AW   = 4,
    parameter int unsigned DEPTH    = 3,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src_a,
    input  logic              id_src_a_used,
    input  logic [REG_AW-1:0] id_src_b,
    input  logic              id_src_b_used,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_wr,
    input  logic              id_is_load,
    input  logic              id_halt,
    input  logic              br_taken,
    output logic              stall,
    output logic              bubble_idex,
    output logic              flush_ifid,
    output logic [1:0]        ex_fwd_a_sel,
    output logic [1:0]        ex_fwd_b_sel,
    output logic              halt_done,
    output logic [15:0]       stall_cnt
);

    localparam int          LAST  = int'(DEPTH) - 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

    typedef struct packed {
        logic       stall;
        logic [1:0] sel;
    } src_res_t;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic              halt_done_d;

    logic [DEPTH-1:0]  ent_valid_q, ent_wr_q, ent_load_q;
    logic [REG_AW-1:0] ent_dst_q [DEPTH];

    logic              in_run, check_en, issue, halt_accept, src_stall;
    src_res_t          res_a, res_b;

    // Youngest matching entry decides the outcome for one source operand.
    function automatic src_res_t lookup(input logic [REG_AW-1:0] src, input logic used);
        src_res_t res;
        logic     found;
        res   = '0;
        found = 1'b0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (!found && used && ent_valid_q[k] && ent_wr_q[k] && (ent_dst_q[k] == src) &&
                !(ZERO_REG && (src == '0))) begin
                found = 1'b1;
`ifdef FWD_EN
                if (k == 0) begin
                    res.stall = ent_load_q[0];
                    res.sel   = ent_load_q[0] ? 2'd0 : 2'd1;
                end else if (k == 1) begin
                    res.sel = 2'd2;
                end else if (k < LAST) begin
                    res.stall = 1'b1;
                end
`else
                if (k < LAST) begin
                    res.stall = 1'b1;
                end
`endif
            end
        end
        return res;
    endfunction

    always_comb begin
        in_run   = (state_q == StRun);
        check_en = id_valid && in_run;
        res_a    = '0;
        res_b    = '0;
        if (check_en) begin
            res_a = lookup(id_src_a, id_src_a_used);
            res_b = lookup(id_src_b, id_src_b_used);
        end
        src_stall = res_a.stall || res_b.stall;
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            drain_cnt_q <= '0;
            halt_done   <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            halt_done   <= halt_done_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        unique case (state_q)
            StRun: begin
                if (halt_accept) begin
                    state_d     = StDrain;
                    drain_cnt_d = CNT_W'(DEPTH);
                end
            end
            StDrain: begin
                drain_cnt_d = drain_cnt_q - CNT_W'(1);
                if (drain_cnt_q <= CNT_W'(1)) begin
                    drain_cnt_d = '0;
                    state_d     = StHalted;
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d     = StRun;
                drain_cnt_d = '0;
            end
        endcase
        halt_done_d = halt_done || (state_d == StHalted);
    end

    // FSM: outputs
    always_comb begin
        stall       = src_stall || !in_run;
        bubble_idex = stall;
        flush_ifid  = id_valid && br_taken && !stall;
        issue       = id_valid && !stall;
        halt_accept = issue && id_halt;
    end

    // Entry 0 is EX; the oldest entry falls off the end after WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_valid_q <= '0;
            ent_wr_q    <= '0;
            ent_load_q  <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                ent_dst_q[k] <= '0;
            end
        end else begin
            ent_valid_q <= {ent_valid_q[DEPTH-2:0], issue};
            ent_wr_q    <= {ent_wr_q[DEPTH-2:0], issue && id_wr && !id_halt};
            ent_load_q  <= {ent_load_q[DEPTH-2:0], issue && id_is_load && !id_halt};
            for (int k = 1; k < int'(DEPTH); k++) begin
                ent_dst_q[k] <= ent_dst_q[k-1];
            end
            ent_dst_q[0] <= issue ? id_dst : '0;
        end
    end

`ifdef FWD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_fwd_a_sel <= 2'd0;
            ex_fwd_b_sel <= 2'd0;
        end else begin
            ex_fwd_a_sel <= issue ? res_a.sel : 2'd0;
            ex_fwd_b_sel <= issue ? res_b.sel : 2'd0;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd   = ^{res_a.sel, res_b.sel, ent_load_q};
    assign ex_fwd_a_sel = 2'd0;
    assign ex_fwd_b_sel = 2'd0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    a_bubble_is_stall: assert property (@(posedge clk) disable iff (rst) bubble_idex == stall);
    a_no_flush_on_stall: assert property (@(posedge clk) disable iff (rst) !(flush_ifid && stall));
    a_halt_done_state: assert property (@(posedge clk) disable iff (rst)
                                        halt_done |-> (state_q == StHalted));
    a_sel_legal: assert property (@(posedge clk) disable iff (rst)
                                  (ex_fwd_a_sel != 2'd3) && (ex_fwd_b_sel != 2'd3));

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard/forwarding controller for the in-order pipelined CPU (IF/ID/EX/MEM/WB and deeper variants).
- Keeps a shift-register scoreboard of in-flight destination registers, one entry per stage from EX to WB.
- Produces the load-use stall, the ID/EX bubble, the IF/ID flush for ID-resolved branches, and registered EX-stage forwarding selects.
- Runs the halt-drain sequence that finally raises the CPU halt flag.

Parameters:
REG_AW, 4, register address width (2^REG_AW architectural registers)
DEPTH, 3, scoreboard entries: entry0=EX, entry1=MEM, entry DEPTH-1=WB; legal DEPTH>=3
ZERO_REG, 1, when 1, register 0 is hardwired and never creates a hazard

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
id_valid  input  1  ID holds a real instruction
id_src_a  input  REG_AW  source A register
id_src_a_used  input  1  instruction reads source A
id_src_b  input  REG_AW  source B register
id_src_b_used  input  1  instruction reads source B
id_dst  input  REG_AW  destination register
id_wr  input  1  instruction writes id_dst
id_is_load  input  1  instruction is a memory load
id_halt  input  1  instruction is HLT
br_taken  input  1  branch resolved taken in ID
stall  output  1  hold PC and IF/ID
bubble_idex  output  1  load ID/EX with a NOP
flush_ifid  output  1  clear IF/ID
ex_fwd_a_sel  output  2  EX operand A: 0=regfile, 1=EX/MEM ALU result, 2=MEM/WB writeback data
ex_fwd_b_sel  output  2  same encoding for operand B
halt_done  output  1  pipeline drained after HLT; sticky
stall_cnt  output  16  saturating count of stall cycles

Behaviour:
- Reset (async, rst=1): all entries invalid; ex_fwd_*_sel=0; FSM=RUN; halt_done=0; stall_cnt=0; stall/bubble_idex/flush_ifid evaluate to 0.
- Entry fields: {valid, dst, wr, is_load}. Every clock: entry[k+1]<=entry[k]; entry[0]<=ID fields if id_valid & ~stall & state==RUN, else invalid. Entry DEPTH-1 is discarded.
- Source match: src_used & entry.valid & entry.wr & entry.dst==src & ~(ZERO_REG & src==0). The lowest-index (youngest) matching entry wins.
- Hazard rules, evaluated only when id_valid & state==RUN:
  - Match entry0 with is_load: stall. Otherwise select 1.
  - Match entry1: select 2.
  - Match entry k, 2<=k<=DEPTH-2: stall.
  - Match entry DEPTH-1: select 0 (regfile write-before-read).
- Outputs:
  - stall = any source stalls, OR state!=RUN.
  - bubble_idex = stall.
  - ex_fwd_*_sel are registered at the same edge that loads entry0; they are 0 for bubbles.
- Branch: flush_ifid = id_valid & br_taken & ~stall. When stall and branch occur in the same cycle, stall wins and the branch is re-evaluated next cycle.
- Halt FSM (RUN -> DRAIN -> HALTED):
  - HLT is accepted with id_valid & id_halt & ~stall. It enters entry0 as a non-writing entry and loads a drain counter with DEPTH.
  - DRAIN: decrement the counter each clock; when it reaches 0, go to HALTED.
  - HALTED: halt_done=1 is registered and held until reset. No further issue.
- stall_cnt: increments on every clock with stall=1 (DRAIN and HALTED cycles included); saturates at 16'hFFFF.
- id_valid=0: no hazard check and no stall from sources; a bubble is shifted in.

Optional Feature:
- Macro FWD_EN.
- Defined: forwarding as above.
- Undefined: any source match in entries 0..DEPTH-2 stalls; a match in entry DEPTH-1 selects 0; ex_fwd_*_sel are tied to 0.

Test Plan:
- Reset with rst=1 mid-DRAIN -> halt_done=0, stall=0, all entries invalid, stall_cnt=0 immediately (async).
- ADD r3 then ADD r4,r3,r1 back-to-back -> no stall; ex_fwd_a_sel=1 while the consumer is in EX; with FWD_EN undefined, exactly 2 stall cycles.
- LW r5 then ADD r6,r5,r5 -> stall=1 and bubble_idex=1 for 1 cycle, then ex_fwd_a_sel=ex_fwd_b_sel=2; stall_cnt=1.
- Producer writes r0, consumer reads r0 (ZERO_REG=1) -> no stall, sel=0.
- br_taken=1 with no hazard -> flush_ifid=1 that cycle. br_taken=1 during a load-use stall -> flush_ifid=0 then 1 in the following cycle.
- HLT accepted at edge E (DEPTH=3) -> stall=1 from the following cycle; halt_done=1 after edge E+3 and stays 1; stall_cnt saturates at FFFF after a long hold.
